// File: rtl/mips_regfile_if.sv
// Register-file bus: two operand read ports, one write port and a debug read port.
// The datapath side is the master; the register file is the slave.
interface mips_regfile_if #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 5
);
    logic [DEPTH_LOG2-1:0] ra1;
    logic [DEPTH_LOG2-1:0] ra2;
    logic [WIDTH-1:0]      rd1;
    logic [WIDTH-1:0]      rd2;
    logic                  we;
    logic [DEPTH_LOG2-1:0] wa;
    logic [WIDTH-1:0]      wd;
    logic [DEPTH_LOG2-1:0] dbg_ra;
    logic [WIDTH-1:0]      dbg_rd;

    modport master (
        output ra1, ra2, we, wa, wd, dbg_ra,
        input  rd1, rd2, dbg_rd
    );

    modport slave (
        input  ra1, ra2, we, wa, wd, dbg_ra,
        output rd1, rd2, dbg_rd
    );
endinterface

// File: rtl/mips_regfile.sv
// 2**DEPTH_LOG2 x WIDTH MIPS register file: register 0 hard-wired to zero,
// two combinational operand ports with optional write-through, one unbypassed debug port.
module mips_regfile #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 5,
    parameter int BYPASS     = 1
) (
    input  logic           clk,
    input  logic           reset,
    mips_regfile_if.slave  bus
);
    localparam int DEPTH   = 2 ** DEPTH_LOG2;
    localparam bit USE_BYP = (BYPASS != 0);

    logic [WIDTH-1:0] r_regs   [1:DEPTH-1];
    logic [WIDTH-1:0] w_stored [0:DEPTH-1];
    logic             w_wr_en;

    // A write to r0 or during reset must neither update state nor bypass.
    assign w_wr_en = bus.we && !reset && (bus.wa != '0);

    // NOTE: the array is built from flip-flops, not RAM, so clearing every entry
    // on reset is legal and required; a RAM macro could not be reset this way.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[bus.wa] <= bus.wd;
        end
    end

    // Stored view with r0 reading as constant zero.
    always_comb begin
        w_stored[0] = '0;
        for (int i = 1; i < DEPTH; i++) begin
            w_stored[i] = r_regs[i];
        end
    end

    always_comb begin
        bus.rd1 = w_stored[bus.ra1];
        bus.rd2 = w_stored[bus.ra2];
        if (USE_BYP && w_wr_en && (bus.wa == bus.ra1)) begin
            bus.rd1 = bus.wd;
        end
        if (USE_BYP && w_wr_en && (bus.wa == bus.ra2)) begin
            bus.rd2 = bus.wd;
        end
    end

    assign bus.dbg_rd = w_stored[bus.dbg_ra];
endmodule

// File: tb/tb_mips_regfile.sv
// Scoreboard bench for mips_regfile: a write-through and a non-bypassed instance
// are driven with identical directed vectors; a monitor pops expected values and compares.
module tb_mips_regfile;
    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    exp_t exp_q[$];
    event sample_ev;

    mips_regfile_if #(.WIDTH(32), .DEPTH_LOG2(5)) bus_byp ();
    mips_regfile_if #(.WIDTH(32), .DEPTH_LOG2(5)) bus_nob ();

    mips_regfile #(.WIDTH(32), .DEPTH_LOG2(5), .BYPASS(1)) u_dut_byp (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_byp)
    );

    mips_regfile #(.WIDTH(32), .DEPTH_LOG2(5), .BYPASS(0)) u_dut_nob (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra1, input logic [4:0] ra2, input logic [4:0] dbg);
        bus_byp.we = we;  bus_byp.wa = wa;  bus_byp.wd = wd;
        bus_byp.ra1 = ra1; bus_byp.ra2 = ra2; bus_byp.dbg_ra = dbg;
        bus_nob.we = we;  bus_nob.wa = wa;  bus_nob.wd = wd;
        bus_nob.ra1 = ra1; bus_nob.ra2 = ra2; bus_nob.dbg_ra = dbg;
    endtask

    // Expected values: write-through instance (rd1, rd2, dbg), then non-bypassed instance.
    task automatic expect_all(input string name,
                              input logic [31:0] b_rd1, input logic [31:0] b_rd2, input logic [31:0] b_dbg,
                              input logic [31:0] n_rd1, input logic [31:0] n_rd2, input logic [31:0] n_dbg);
        exp_q.push_back('{name, 0, b_rd1});
        exp_q.push_back('{name, 1, b_rd2});
        exp_q.push_back('{name, 2, b_dbg});
        exp_q.push_back('{name, 3, n_rd1});
        exp_q.push_back('{name, 4, n_rd2});
        exp_q.push_back('{name, 5, n_dbg});
        -> sample_ev;
        #1;
    endtask

    task automatic write_reg(input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        drive(1'b1, wa, wd, 5'd0, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    endtask

    function automatic logic [31:0] sweep_val(input int a);
        logic [31:0] v;
        v = (a == 0) ? 32'h0 : 32'(a) * 32'h0101_0101;
        return v;
    endfunction

    // Monitor: drains the scoreboard whenever the stimulus marks outputs as settled.
    initial begin
        exp_t        e;
        logic [31:0] act;
        string       port;
        forever begin
            @(sample_ev);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                case (e.sel)
                    0: begin act = bus_byp.rd1;    port = "byp.rd1"; end
                    1: begin act = bus_byp.rd2;    port = "byp.rd2"; end
                    2: begin act = bus_byp.dbg_rd; port = "byp.dbg"; end
                    3: begin act = bus_nob.rd1;    port = "nob.rd1"; end
                    4: begin act = bus_nob.rd2;    port = "nob.rd2"; end
                    default: begin act = bus_nob.dbg_rd; port = "nob.dbg"; end
                endcase
                n_tests++;
                if (act !== e.val) begin
                    n_fail++;
                    $display("FAIL %s %s: got %h expected %h", e.name, port, act, e.val);
                end
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        #12;
        reset = 1'b0;

        // Prior contents, then asynchronous clear with no clock edge in between.
        write_reg(5'd3, 32'hCAFE_0003);
        write_reg(5'd7, 32'hBEEF_0007);
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd7, 5'd3);
        #1;
        expect_all("pre_reset", 32'hCAFE_0003, 32'hBEEF_0007, 32'hCAFE_0003,
                                32'hCAFE_0003, 32'hBEEF_0007, 32'hCAFE_0003);
        reset = 1'b1;
        #1;
        expect_all("async_clear", 0, 0, 0, 0, 0, 0);
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a), 5'(a));
            #1;
            expect_all("reset_sweep", 0, 0, 0, 0, 0, 0);
        end

        // Write to r0 is a no-op and never bypasses.
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0);
        #1;
        expect_all("r0_write_pre", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        #1;
        expect_all("r0_write_post", 0, 0, 0, 0, 0, 0);

        // Basic write/read on consecutive edges.
        write_reg(5'd8, 32'h0000_1234);
        write_reg(5'd9, 32'hFFFF_FFFF);
        drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd9, 5'd9);
        #1;
        expect_all("basic_rw", 32'h0000_1234, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'h0000_1234, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Same-cycle write: bypassed vs. stored value, debug never bypassed.
        write_reg(5'd5, 32'h11);
        @(negedge clk);
        drive(1'b1, 5'd5, 32'h22, 5'd5, 5'd5, 5'd5);
        #1;
        expect_all("bypass_pre", 32'h22, 32'h22, 32'h11, 32'h11, 32'h11, 32'h11);
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
        #1;
        expect_all("bypass_post", 32'h22, 32'h22, 32'h22, 32'h22, 32'h22, 32'h22);

        // Reset mid-cycle with a write pending: the write is lost.
        write_reg(5'd31, 32'hA5A5_A5A5);
        @(negedge clk);
        drive(1'b1, 5'd31, 32'h5A5A_5A5A, 5'd31, 5'd31, 5'd31);
        #1;
        expect_all("mid_pre", 32'h5A5A_5A5A, 32'h5A5A_5A5A, 32'hA5A5_A5A5,
                              32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        reset = 1'b1;
        #1;
        expect_all("mid_in_reset", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        expect_all("mid_edge_in_reset", 0, 0, 0, 0, 0, 0);
        drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd31, 5'd31);
        @(negedge clk);
        reset = 1'b0;
        #1;
        expect_all("mid_after_reset", 0, 0, 0, 0, 0, 0);
        write_reg(5'd31, 32'h0000_0077);
        drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd31, 5'd31);
        #1;
        expect_all("first_write_after_reset", 32'h77, 32'h77, 32'h77, 32'h77, 32'h77, 32'h77);

        // Full sweep: r[i] = i * 0x01010101, read pairs (i, 32-i).
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), sweep_val(i));
        end
        for (int i = 0; i < 32; i++) begin
            logic [4:0] a2;
            a2 = 5'(32 - i);
            drive(1'b0, 5'd0, 32'h0, 5'(i), a2, 5'(i));
            #1;
            expect_all("sweep", sweep_val(i), sweep_val(int'(a2)), sweep_val(i),
                                sweep_val(i), sweep_val(int'(a2)), sweep_val(i));
        end

        #2;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
